// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing for the 800x600 @ 60 Hz video pipeline
// (40 MHz pixel clock). Downstream drawing stages use the same constants
// for their bounds checks, so keep them here rather than in any one block.
//
// Contents:
//   HOR_* / VER_*  - visible size, sync placement and totals
//   coord_t        - 11-bit raster coordinate
//   in_window()    - unsigned half-open window test used for sync decode

package vga_pkg;

    localparam int unsigned HOR_PIXELS     = 800;
    localparam int unsigned HOR_SYNC_START = 840;
    localparam int unsigned HOR_SYNC_WIDTH = 128;
    localparam int unsigned HOR_TOTAL      = 1056;

    localparam int unsigned VER_PIXELS     = 600;
    localparam int unsigned VER_SYNC_START = 601;
    localparam int unsigned VER_SYNC_WIDTH = 4;
    localparam int unsigned VER_TOTAL      = 628;

    localparam int unsigned COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // lo <= v < lo + width, all unsigned; width is widened so that
    // lo + width == 2048 does not wrap.
    function automatic logic in_window(coord_t v, coord_t lo, logic [COORD_W:0] width);
        logic [COORD_W:0] v_w;
        logic [COORD_W:0] lo_w;
        v_w  = {1'b0, v};
        lo_w = {1'b0, lo};
        return (v_w >= lo_w) && (v_w < (lo_w + width));
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: pixel stream passed along the video pipeline.
//
// Signals:
//   hcount, vcount  - coordinate of the pixel described in this cycle
//   hsync, vsync    - active-high sync
//   hblnk, vblnk    - outside the visible area
//   rgb             - 4:4:4 colour
//
// Modports: out/master (producer), in/slave (consumer).

interface vga_if;
    import vga_pkg::*;

    coord_t      hcount;
    coord_t      vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up-counter with enable and async active-low clear.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous clear, active low
//   en         in   advance by one on this edge
//   count_nxt  out  value the counter takes if it advances now
//   wrap       out  en is high and the counter is at N-1 (rolls to 0 now)

module mod_counter #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;
    logic         at_last;

    assign at_last   = (count == LAST);
    assign count_nxt = at_last ? '0 : count + W'(1);
    assign wrap      = en && at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator at the head of the video
// pipeline. Owns the horizontal/vertical counters, decodes sync and blanking
// and drives black rgb into the vga_if stream.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active low
//   en           in   pixel advance enable; 0 freezes the raster
//   vga_out      vga_if.out  registered pixel stream
//   frame_start  out  one-cycle pulse when the outputs wrap to pixel (0,0)
//   frame_cnt    out  [15:0] frames started since reset, modulo 2^16
//                     (only when VGA_TIMING_FRAME_CNT_EN is defined)
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.

module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = HOR_PIXELS,
    parameter int unsigned H_SYNC_START = HOR_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = HOR_SYNC_WIDTH,
    parameter int unsigned H_TOTAL      = HOR_TOTAL,
    parameter int unsigned V_ACTIVE     = VER_PIXELS,
    parameter int unsigned V_SYNC_START = VER_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = VER_SYNC_WIDTH,
    parameter int unsigned V_TOTAL      = VER_TOTAL
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   vga_out,
    output logic frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START + H_SYNC_WIDTH <= H_TOTAL
          && H_TOTAL <= 2048 && V_ACTIVE < V_SYNC_START
          && V_SYNC_START + V_SYNC_WIDTH <= V_TOTAL && V_TOTAL <= 2048)) begin : g_bad_params
        $error("vga_timing: inconsistent timing parameters");
    end

    localparam coord_t             H_ACT = COORD_W'(H_ACTIVE);
    localparam coord_t             V_ACT = COORD_W'(V_ACTIVE);
    localparam coord_t             H_SS  = COORD_W'(H_SYNC_START);
    localparam coord_t             V_SS  = COORD_W'(V_SYNC_START);
    localparam logic [COORD_W:0]   H_SW  = (COORD_W + 1)'(H_SYNC_WIDTH);
    localparam logic [COORD_W:0]   V_SW  = (COORD_W + 1)'(V_SYNC_WIDTH);

    coord_t h_nxt;
    coord_t v_nxt;
    logic   h_wrap;
    logic   v_wrap;

    mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_h_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    // h_wrap already carries en, so the line counter only moves on an
    // enabled end-of-line edge.
    mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_v_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (h_wrap),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    // Vertical next value only applies when the line actually ends.
    coord_t v_next_line;
    assign v_next_line = h_wrap ? v_nxt : vga_out.vcount;

    // Decode the values the counters are about to take, so every registered
    // field describes the same pixel as hcount/vcount.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
            frame_start    <= 1'b0;
        end else begin
            vga_out.rgb <= '0;
            frame_start <= v_wrap;
            if (en) begin
                vga_out.hcount <= h_nxt;
                vga_out.vcount <= v_next_line;
                vga_out.hblnk  <= (h_nxt >= H_ACT);
                vga_out.vblnk  <= (v_next_line >= V_ACT);
                vga_out.hsync  <= in_window(h_nxt, H_SS, H_SW);
                vga_out.vsync  <= in_window(v_next_line, V_SS, V_SW);
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed + randomised-enable bench for vga_timing, run with
// a reduced raster so several whole frames fit in a short run. The reference
// model tracks only the linear pixel index since reset and derives every
// expected output from it with division/modulo and the window rules.

module tb_vga_timing;

    localparam int HA  = 16;
    localparam int HSS = 20;
    localparam int HSW = 4;
    localparam int HT  = 26;
    localparam int VA  = 6;
    localparam int VSS = 7;
    localparam int VSW = 2;
    localparam int VT  = 10;
    localparam int FR  = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_if vga_bus ();

    vga_timing #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .V_TOTAL(VT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .vga_out     (vga_bus),
        .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pix    = 0;      // pixel index within the frame
    logic        in_rst = 1'b1;
    logic        exp_fs = 1'b0;
    logic [15:0] frames = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int eh, ev;
        eh = pix % HT;
        ev = pix / HT;
        if (in_rst) begin
            eh = 0;
            ev = 0;
        end
        chk("hcount", 32'(vga_bus.hcount), 32'(eh));
        chk("vcount", 32'(vga_bus.vcount), 32'(ev));
        chk("hblnk",  32'(vga_bus.hblnk),  32'(!in_rst && eh >= HA));
        chk("vblnk",  32'(vga_bus.vblnk),  32'(!in_rst && ev >= VA));
        chk("hsync",  32'(vga_bus.hsync),  32'(!in_rst && eh >= HSS && eh < HSS + HSW));
        chk("vsync",  32'(vga_bus.vsync),  32'(!in_rst && ev >= VSS && ev < VSS + VSW));
        chk("rgb",    32'(vga_bus.rgb),    32'(0));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(frames));
`endif
    endtask

    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        if (e) begin
            pix    = (pix + 1) % FR;
            exp_fs = (pix == 0);
            if (exp_fs) frames = frames + 16'd1;
        end else begin
            exp_fs = 1'b0;
        end
        #1;
        check_model();
    endtask

    initial begin
        int fs_seen;
        int hs_len;
        int guard;

        // Power-on reset.
        #12;
        check_model();
        @(negedge clk);
        rst    = 1'b1;
        in_rst = 1'b0;
        pix    = 0;

        // First enabled edge presents (1,0); then one whole frame.
        step(1'b1);
        chk("first_edge_h", 32'(vga_bus.hcount), 32'(1));
        fs_seen = 0;
        hs_len  = 0;
        for (int i = 1; i < FR; i++) begin
            step(1'b1);
            if (frame_start) fs_seen++;
            if (vga_bus.hsync && vga_bus.vcount == 0) hs_len++;
        end
        chk("frame_start_once", 32'(fs_seen), 32'(1));
        chk("frame_end_fs", 32'(frame_start), 32'(1));
        chk("hsync_len", 32'(hs_len), 32'(HSW));

        // Enable gating just before the hsync window.
        guard = 0;
        while ((pix % HT) != HSS - 1 && guard < 2 * HT) begin
            step(1'b1);
            guard++;
        end
        chk("gate_reach", 32'(vga_bus.hcount), 32'(HSS - 1));
        for (int i = 0; i < 7; i++) step(1'b0);
        chk("gate_hold_hsync", 32'(vga_bus.hsync), 32'(0));
        step(1'b1);
        chk("gate_hsync_rise", 32'(vga_bus.hsync), 32'(1));

        // Mid-frame asynchronous reset.
        for (int i = 0; i < 40; i++) step(1'b1);
        #2;
        rst    = 1'b0;
        in_rst = 1'b1;
        exp_fs = 1'b0;
        frames = '0;
        #1;
        check_model();
        for (int i = 0; i < 5; i++) step(1'b1);
        @(negedge clk);
        rst    = 1'b1;
        in_rst = 1'b0;
        pix    = 0;
        step(1'b1);
        chk("post_rst_h", 32'(vga_bus.hcount), 32'(1));
        chk("post_rst_v", 32'(vga_bus.vcount), 32'(0));

        // Randomised enable over several frames.
        for (int i = 0; i < 4 * FR; i++) step(logic'($urandom_range(0, 3) != 0));

`ifdef VGA_TIMING_FRAME_CNT_EN
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        frames = 16'hFFFF;
        guard = 0;
        do begin
            step(1'b1);
            guard++;
        end while (!exp_fs && guard < FR + 2);
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster generator: the producer end of the `vga_if` pixel stream that the drawing stages (background, paddles, ball) consume and forward. It owns the horizontal and vertical counters, decodes sync and blanking, and drives a black `rgb` so that the first drawing stage starts from a known colour. It sits at the head of the video pipeline, directly after the clock/reset generation.

## Interface
Parameters (defaults come from `vga_pkg`; 800x600 at 60 Hz with a 40 MHz pixel clock):
- `H_ACTIVE`, `HOR_PIXELS` (800): visible columns.
- `H_SYNC_START`, 840: first hcount with hsync asserted.
- `H_SYNC_WIDTH`, 128: hsync length in pixels.
- `H_TOTAL`, 1056: pixels per line.
- `V_ACTIVE`, `VER_PIXELS` (600): visible lines.
- `V_SYNC_START`, 601: first vcount with vsync asserted.
- `V_SYNC_WIDTH`, 4: vsync length in lines.
- `V_TOTAL`, 628: lines per frame.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: **reset is asynchronous and active-low**; one clock domain, `clk`.
- `en` in 1: pixel advance enable. When it is 0, the raster freezes.
- `vga_out` `vga_if.out`: `hcount[10:0]`, `vcount[10:0]`, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb[11:0]`.
- `frame_start` out 1: one-cycle pulse that fires when the raster enters pixel (0,0).

## Operation
- Internal state is a pair of counters, `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1).
- On each `clk` edge with `en`=1:
  - `h_cnt` increments.
  - At `H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (`H_TOTAL-1`, `V_TOTAL-1`), both counters wrap to 0.
- With `en`=0, all state and all outputs hold their values, and `frame_start` is 0.
- Decode is applied to the next counter values, and every output is registered, so all fields of `vga_out` describe the same pixel in the same cycle:
  - `hblnk` = hcount >= H_ACTIVE.
  - `vblnk` = vcount >= V_ACTIVE.
  - `hsync` = H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH. Polarity is active-high.
  - `vsync` = V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_WIDTH.
  - `rgb` = 12'h0_0_0 at all times.
- `frame_start` = 1 in exactly the cycle in which the outputs first present hcount=0, vcount=0 after a wrap.
- Reset (`rst`=0), asynchronous:
  - `hcount`=0, `vcount`=0, `hsync`=0, `vsync`=0, `hblnk`=0, `vblnk`=0, `rgb`=0, `frame_start`=0.
  - Counters are cleared to 0.
  - The block resumes from pixel (0,0) on the first enabled edge after deassertion. That first edge presents (1,0).
  - Reset mid-frame discards the frame; no partial sync pulse is completed.
- Arithmetic:
  - Counters are 11 bits.
  - Comparisons are unsigned.
  - Parameters must satisfy ACTIVE < SYNC_START, and SYNC_START+SYNC_WIDTH <= TOTAL <= 2048. These are checked by an elaboration-time assertion.

## Timing
- Output latency is 0 cycles relative to the counter state. Each `vga_out` field is a flop output.
- Line period is H_TOTAL enabled cycles. Frame period is H_TOTAL*V_TOTAL enabled cycles (663 168 at the defaults).
- hsync is high for exactly H_SYNC_WIDTH enabled cycles per line.
- vsync is high for exactly V_SYNC_WIDTH complete lines. It rises and falls together with hcount=0.
- `frame_start` is high for exactly one enabled cycle per frame and never during reset.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- Defined:
  - Adds output `frame_cnt` [15:0], reset to 0.
  - `frame_cnt` increments, modulo 2^16, in the same cycle that `frame_start` is asserted.
  - Game logic uses it for ball-speed and serve timing.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Structure
- `vga_pkg` holds the shared timing constants:
  - `HOR_PIXELS`, `VER_PIXELS`, `HOR_TOTAL`, `VER_TOTAL`, `HOR_SYNC_START`, `HOR_SYNC_WIDTH`, `VER_SYNC_START`, `VER_SYNC_WIDTH`.
  - Downstream blocks use the same constants for bounds checks.
- One sub-module, `mod_counter`: a parameterised modulo-N counter with enable, wrap-pulse output and async active-low clear.
- It is instantiated twice:
  - Horizontal instance, advanced by `en`.
  - Vertical instance, advanced by the horizontal wrap pulse AND `en`.
- Sync, blank and frame-start decode plus output registers live in the top module.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles mid-frame → all `vga_out` fields and `frame_start` read 0 immediately, without waiting for a clock edge. The first enabled edge after release gives hcount=1, vcount=0.
- **Line timing:** run 1056 cycles from reset →
  - hblnk rises at hcount=800.
  - hsync is high for hcount 840..967 (128 cycles).
  - hcount wraps 1055→0 and vcount goes 0→1 on the same edge.
- **Frame timing:** run one full frame →
  - vblnk is high for vcount 600..627.
  - vsync is high for vcount 601..604 only.
  - `frame_start` is asserted exactly once, after 663 168 cycles, with hcount=vcount=0.
- **Enable gating:** toggle `en` low for 7 cycles at hcount=839 → all outputs hold; hsync asserts only on the next enabled edge. Line length measured in enabled cycles remains 1056.
- **Frame counter** (macro defined): run 3 frames → `frame_cnt` reads 3. Preload by forcing to 16'hFFFF → the next frame_start wraps it to 0.
- **Consistency:** a scoreboard recomputes sync and blank from the output hcount/vcount every cycle for 2 frames → zero mismatches, and rgb is 0 throughout.
